// File: rtl/sipo_frame_rx.sv
//------------------------------------------------------------------------------
// Module   : sipo_frame_rx
// Purpose  : Serial-in/parallel-out frame receiver. It assembles N strobed
//            serial bits, MSB-first or LSB-first as chosen per frame, into a
//            word. Each completed word goes into a one-deep valid/ready output
//            buffer. A sticky overrun flag records every word that was dropped
//            because the buffer was still full.
// Options  : define SIPO_FRAME_RX_PARITY_EN to expect one trailing even-parity
//            bit per frame. The word then completes on that parity bit, and
//            parity_err reports a mismatch.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sipo_frame_rx #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         frame_start,
  input  logic         dir,
  input  logic         clr_ovr,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  input  logic         data_ready,
  output logic         busy,
  output logic         overrun,
  output logic         parity_err
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1
`ifdef SIPO_FRAME_RX_PARITY_EN
    ,
    S_PAR   = 2'd2
`endif
  } state_t;

  state_t          state;
  logic [N-1:0]    sr;
  logic [CW-1:0]   count;
  logic            dir_q;

  logic [N-1:0]    shifted;
  logic [N-1:0]    first_word;
  logic            last_bit;
  logic            bit_in;
  logic            complete;
  logic [N-1:0]    word;
  logic            word_perr;
  logic            take;

  // Next shift-register value, completion detection and the word offered to the buffer.
  always_comb begin
    shifted    = dir_q ? {sin, sr[N-1:1]} : {sr[N-2:0], sin};
    first_word = dir ? {sin, {(N-1){1'b0}}} : {{(N-1){1'b0}}, sin};
    last_bit   = (count == CW'(N - 1));
    bit_in     = sin_valid & ~frame_start;
    complete   = 1'b0;
    word       = shifted;
    word_perr  = 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
    // The data word is already held in sr. The incoming bit is the parity bit.
    if ((state == S_PAR) && bit_in) begin
      complete  = 1'b1;
      word      = sr;
      word_perr = ^{sr, sin};
    end
`else
    if ((state == S_SHIFT) && bit_in && last_bit) begin
      complete = 1'b1;
    end
`endif
    take = complete & (~data_valid | data_ready);
  end

  // Frame FSM: a frame_start in any state begins a fresh frame (resync).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      sr    <= '0;
      count <= '0;
      dir_q <= 1'b0;
    end else if (sin_valid) begin
      if (frame_start) begin
        sr    <= first_word;
        dir_q <= dir;
        count <= CW'(1);
        state <= S_SHIFT;
      end else begin
        case (state)
          S_IDLE: ;
          S_SHIFT: begin
            sr <= shifted;
            if (last_bit) begin
              count <= '0;
`ifdef SIPO_FRAME_RX_PARITY_EN
              state <= S_PAR;
`else
              state <= S_IDLE;
`endif
            end else begin
              count <= count + CW'(1);
            end
          end
`ifdef SIPO_FRAME_RX_PARITY_EN
          S_PAR: begin
            state <= S_IDLE;
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // One-deep output buffer. A word that completes while the buffer is full and not being read is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
    end else if (take) begin
      data_out   <= word;
      data_valid <= 1'b1;
      parity_err <= word_perr;
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
    end
  end

  // Sticky overrun flag. A new drop takes priority over a clear on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (complete && data_valid && !data_ready) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sipo_frame_rx.sv
//------------------------------------------------------------------------------
// Module   : tb_sipo_frame_rx
// Purpose  : Self-checking bench for sipo_frame_rx. Vector table frames, an
//            output scoreboard, and directed overrun/resync/reset sequences.
//            Honours SIPO_FRAME_RX_PARITY_EN when it is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sipo_frame_rx;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         sin;
  logic         sin_valid;
  logic         frame_start;
  logic         dir;
  logic         clr_ovr;
  logic         data_ready;
  logic [N-1:0] data_out;
  logic         data_valid;
  logic         busy;
  logic         overrun;
  logic         parity_err;

  sipo_frame_rx #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .sin         (sin),
    .sin_valid   (sin_valid),
    .frame_start (frame_start),
    .dir         (dir),
    .clr_ovr     (clr_ovr),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .busy        (busy),
    .overrun     (overrun),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] word;
    logic       perr;
  } exp_t;

  typedef struct {
    logic [7:0] bits;   // transmit order, bits[7] is sent first
    logic       d;
    int         gap;
    logic [7:0] expw;
    logic       pbit;
    logic       eperr;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // Without the parity option parity_err is always 0.
  function automatic exp_t mk(input logic [7:0] w, input logic pe);
    exp_t e;
    e.word = w;
`ifdef SIPO_FRAME_RX_PARITY_EN
    e.perr = pe;
`else
    e.perr = 1'b0;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Every transfer the DUT makes is matched against the oldest expected word.
  always @(negedge clk) begin
    if (!reset && data_valid && data_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected actual=%0h required=none", data_out);
      end else begin
        mon_e = sb.pop_front();
        if (data_out !== mon_e.word || parity_err !== mon_e.perr) begin
          failures++;
          $display("FAIL sb_word actual=%0h/%0b required=%0h/%0b",
                   data_out, parity_err, mon_e.word, mon_e.perr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fs, input logic d);
    sin         = b;
    frame_start = fs;
    dir         = d;
    sin_valid   = 1'b1;
    tick();
    sin_valid   = 1'b0;
    frame_start = 1'b0;
    sin         = 1'b0;
  endtask

  // Sends one frame. rdy_last raises data_ready together with the completing bit.
  task automatic send_frame(input logic [7:0] bits, input logic d, input int gap,
                            input logic pbit, input logic rdy_last);
    logic [7:0] hold;
    for (int i = 7; i >= 0; i--) begin
`ifndef SIPO_FRAME_RX_PARITY_EN
      if (i == 0 && rdy_last) data_ready = 1'b1;
`endif
      send_bit(bits[i], (i == 7), d);
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          hold = data_out;
          tick();
          chk("gap_busy", {31'd0, busy}, 32'd1);
          chk("gap_hold", {24'd0, data_out}, {24'd0, hold});
        end
      end
    end
`ifdef SIPO_FRAME_RX_PARITY_EN
    chk("par_wait_busy", {31'd0, busy}, 32'd1);
    if (rdy_last) data_ready = 1'b1;
    send_bit(pbit, 1'b0, d);
`endif
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'b10100101, 1'b0, 0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'b10100101, 1'b0, 0, 8'hA5, 1'b1, 1'b1};
    vecs[2] = '{8'b00111100, 1'b1, 3, 8'h3C, 1'b0, 1'b0};
    vecs[3] = '{8'b11110000, 1'b1, 0, 8'h0F, 1'b0, 1'b0};
    vecs[4] = '{8'b00000001, 1'b0, 1, 8'h01, 1'b1, 1'b0};
    vecs[5] = '{8'b10000000, 1'b1, 2, 8'h01, 1'b0, 1'b1};
    vecs[6] = '{8'b11001010, 1'b1, 0, 8'h53, 1'b0, 1'b0};

    reset = 1'b1; sin = 1'b0; sin_valid = 1'b0; frame_start = 1'b0;
    dir = 1'b0; clr_ovr = 1'b0; data_ready = 1'b1;
    tick(); tick();
    chk("rst_data",    {24'd0, data_out}, 32'd0);
    chk("rst_valid",   {31'd0, data_valid}, 32'd0);
    chk("rst_busy",    {31'd0, busy}, 32'd0);
    chk("rst_ovr",     {31'd0, overrun}, 32'd0);
    chk("rst_perr",    {31'd0, parity_err}, 32'd0);
    reset = 1'b0;
    tick();

    // Table-driven frames with the consumer always ready.
    for (int v = 0; v < 7; v++) begin
      sb.push_back(mk(vecs[v].expw, vecs[v].eperr));
      send_frame(vecs[v].bits, vecs[v].d, vecs[v].gap, vecs[v].pbit, 1'b0);
      chk("vec_valid", {31'd0, data_valid}, 32'd1);
      chk("vec_busy",  {31'd0, busy}, 32'd0);
      chk("vec_data",  {24'd0, data_out}, {24'd0, vecs[v].expw});
      chk("vec_perr",  {31'd0, parity_err}, {31'd0, mk(vecs[v].expw, vecs[v].eperr).perr});
      tick();
      chk("vec_valid_1cyc", {31'd0, data_valid}, 32'd0);
    end

    // Overrun: the second word is dropped and the first one is kept.
    data_ready = 1'b0;
    sb.push_back(mk(8'h11, 1'b0));
    send_frame(8'h11, 1'b0, 0, 1'b0, 1'b0);
    chk("ovr_first_valid", {31'd0, data_valid}, 32'd1);
    send_frame(8'h22, 1'b0, 0, 1'b0, 1'b0);
    chk("ovr_data_kept", {24'd0, data_out}, 32'h11);
    chk("ovr_set",       {31'd0, overrun}, 32'd1);
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
    chk("ovr_cleared",   {31'd0, overrun}, 32'd0);
    data_ready = 1'b1; tick();
    chk("ovr_consumed",  {31'd0, data_valid}, 32'd0);
    data_ready = 1'b0;

    // A drop on the same edge as clr_ovr sets the flag.
    sb.push_back(mk(8'h33, 1'b0));
    send_frame(8'h33, 1'b0, 0, 1'b0, 1'b0);
    clr_ovr = 1'b1;
    send_frame(8'h44, 1'b0, 0, 1'b0, 1'b0);
    clr_ovr = 1'b0;
    chk("ovr_set_wins", {31'd0, overrun}, 32'd1);
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
    data_ready = 1'b1; tick();
    chk("ovr2_consumed", {31'd0, data_valid}, 32'd0);
    data_ready = 1'b0;

    // Load and consume on the same edge.
    sb.push_back(mk(8'h11, 1'b0));
    send_frame(8'h11, 1'b0, 0, 1'b0, 1'b0);
    sb.push_back(mk(8'h22, 1'b0));
    send_frame(8'h22, 1'b0, 0, 1'b0, 1'b1);
    chk("sim_data",  {24'd0, data_out}, 32'h22);
    chk("sim_valid", {31'd0, data_valid}, 32'd1);
    chk("sim_ovr",   {31'd0, overrun}, 32'd0);
    tick();
    chk("sim_drain", {31'd0, data_valid}, 32'd0);

    // Resync: a partial frame of 3 bits is discarded by a new frame_start.
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    sb.push_back(mk(8'h5A, 1'b0));
    send_frame(8'h5A, 1'b0, 0, 1'b0, 1'b0);
    chk("resync_data",  {24'd0, data_out}, 32'h5A);
    chk("resync_valid", {31'd0, data_valid}, 32'd1);
    tick();

    // Asynchronous reset in the middle of a frame.
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_data",  {24'd0, data_out}, 32'd0);
    chk("arst_valid", {31'd0, data_valid}, 32'd0);
    chk("arst_busy",  {31'd0, busy}, 32'd0);
    chk("arst_ovr",   {31'd0, overrun}, 32'd0);
    chk("arst_perr",  {31'd0, parity_err}, 32'd0);
    tick();
    reset = 1'b0;
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    chk("post_rst_busy",  {31'd0, busy}, 32'd0);
    chk("post_rst_valid", {31'd0, data_valid}, 32'd0);

    // The receiver recovers with a normal frame.
    sb.push_back(mk(8'hC3, 1'b0));
    send_frame(8'hC3, 1'b0, 0, 1'b0, 1'b0);
    chk("recover_data", {24'd0, data_out}, 32'hC3);
    tick(); tick();

    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
